// File: rtl/eth_pkg.sv
// Shared constants, state type and CRC helper for the Ethernet TX framer.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_DRAIN,
        ST_IPG
    } txState_t;

    // One byte of reflected CRC-32, data LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_tx_framer_if.sv
// Payload stream in, GMII byte stream and status out.
interface eth_tx_framer_if;

    logic [7:0]  dataIn;
    logic        validIn;
    logic        lastIn;
    logic        readyOut;
    logic [7:0]  txDataOut;
    logic        txEnOut;
    logic        txErrOut;
    logic        busyOut;
    logic [15:0] frameCountOut;

    // Payload source / GMII sink side
    modport master (
        output dataIn, validIn, lastIn,
        input  readyOut, txDataOut, txEnOut, txErrOut, busyOut, frameCountOut
    );

    // Framer side
    modport slave (
        input  dataIn, validIn, lastIn,
        output readyOut, txDataOut, txEnOut, txErrOut, busyOut, frameCountOut
    );

endinterface

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 state register with clear and enable.
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // Clear wins over update so a new frame always starts from CRC_INIT.
    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = CRC_INIT;
        end else if (en_i) begin
            crc_d = crc32_byte(crc_q, data_i);
        end
    end

    // CRC state register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/eth_tx_framer.sv
// Payload stream to GMII frame: preamble, SFD, payload, pad, FCS, IPG.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_BYTES    = 7,
    parameter int MIN_PAYLOAD_BYTES = 60,
    parameter int IPG_BYTES         = 12
) (
    input  logic              clkIn,
    input  logic              rstBIn,
    eth_tx_framer_if.slave    bus
);

    localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_BYTES - 1);
    localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD_BYTES);
    localparam logic [10:0] IPG_LAST = 11'(IPG_BYTES - 1);

    txState_t    state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_err_q, tx_err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic        crc_clr;
    logic        crc_en;
    logic [7:0]  crc_data;
    logic [31:0] crc;
    logic [10:0] cnt_inc;
    logic [7:0]  fcs_bytes [4];

    assign cnt_inc = cnt_q + 11'd1;

    // FCS is the inverted CRC, least significant byte on the wire first.
    for (genvar gi = 0; gi < 4; gi++) begin : g_fcs
        assign fcs_bytes[gi] = ~crc[8*gi +: 8];
    end

    crc32_d8 u_crc (
        .clk_i   (clkIn),
        .rst_n_i (rstBIn),
        .clr_i   (crc_clr),
        .en_i    (crc_en),
        .data_i  (crc_data),
        .crc_o   (crc)
    );

    // Next-state and next-output decode; the output byte is registered on the same edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_data_d   = 8'h00;
        tx_en_d     = 1'b0;
        tx_err_d    = 1'b0;
        frame_cnt_d = frame_cnt_q;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        crc_data    = bus.dataIn;
        case (state_q)
            ST_IDLE: begin
                if (bus.validIn) begin
                    state_d = ST_PREAMBLE;
                    cnt_d   = '0;
                end
            end
            ST_PREAMBLE: begin
                tx_data_d = PREAMBLE_BYTE;
                tx_en_d   = 1'b1;
                if (cnt_q == PRE_LAST) begin
                    state_d = ST_SFD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_SFD: begin
                tx_data_d = SFD_BYTE;
                tx_en_d   = 1'b1;
                crc_clr   = 1'b1;
                state_d   = ST_PAYLOAD;
                cnt_d     = '0;
            end
            ST_PAYLOAD: begin
                tx_en_d = 1'b1;
                if (bus.validIn) begin
                    tx_data_d = bus.dataIn;
                    crc_en    = 1'b1;
                    cnt_d     = cnt_inc;
                    if (bus.lastIn) begin
                        if (cnt_inc < MIN_CNT) begin
                            state_d = ST_PAD;
                        end else begin
                            state_d = ST_FCS;
                            cnt_d   = '0;
                        end
                    end
                end else begin
                    // Source starved mid-frame: poison the frame and discard the rest.
                    tx_err_d = 1'b1;
                    state_d  = ST_DRAIN;
                    cnt_d    = '0;
                end
            end
            ST_PAD: begin
                tx_en_d  = 1'b1;
                crc_en   = 1'b1;
                crc_data = 8'h00;
                if (cnt_inc >= MIN_CNT) begin
                    state_d = ST_FCS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_FCS: begin
                tx_data_d = fcs_bytes[cnt_q[1:0]];
                tx_en_d   = 1'b1;
                if (cnt_q == 11'd3) begin
                    state_d     = ST_IPG;
                    cnt_d       = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DRAIN: begin
                if (bus.validIn && bus.lastIn) begin
                    state_d = ST_IPG;
                    cnt_d   = '0;
                end
            end
            ST_IPG: begin
                if (cnt_q == IPG_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and registered GMII outputs
    always_ff @(posedge clkIn) begin
        if (!rstBIn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tx_data_q   <= 8'h00;
            tx_en_q     <= 1'b0;
            tx_err_q    <= 1'b0;
            frame_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_data_q   <= tx_data_d;
            tx_en_q     <= tx_en_d;
            tx_err_q    <= tx_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.readyOut      = (state_q == ST_PAYLOAD) || (state_q == ST_DRAIN);
    assign bus.busyOut       = (state_q != ST_IDLE);
    assign bus.txDataOut     = tx_data_q;
    assign bus.txEnOut       = tx_en_q;
    assign bus.txErrOut      = tx_err_q;
    assign bus.frameCountOut = frame_cnt_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer with a frame-level expected-byte model.
module tb_eth_tx_framer;

    localparam int          MIN_PAY = 60;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    logic clk;
    logic rstB;

    eth_tx_framer_if bus();

    eth_tx_framer #(
        .PREAMBLE_BYTES    (7),
        .MIN_PAYLOAD_BYTES (60),
        .IPG_BYTES         (12)
    ) dut (
        .clkIn  (clk),
        .rstBIn (rstB),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pay [256];
    logic [8:0] exp_q [$];     // {txErr, txData} for every txEn-high cycle
    logic [7:0] cap [$];

    bit          started    = 0;
    bit          prev_en    = 0;
    bit          frame_bad  = 0;
    int          run        = 0;
    int          lo_run     = 0;
    int          last_len   = 0;
    int          last_gap   = 0;
    int          rdy_cnt    = 0;
    int          en_cnt     = 0;
    logic [31:0] last_res   = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Bit-serial reference CRC, LSB first
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            logic fb;
            fb = r[0] ^ b[k];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    // Expected wire image of one frame from the framing rules.
    task automatic push_exp(input int off, input int n, input int under_at);
        logic [31:0] c;
        logic [31:0] fcs;
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        if (under_at > 0) begin
            for (int i = 0; i < under_at; i++) exp_q.push_back({1'b0, pay[off+i]});
            exp_q.push_back({1'b1, 8'h00});
        end else begin
            c = 32'hFFFFFFFF;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({1'b0, pay[off+i]});
                c = crc_upd(c, pay[off+i]);
            end
            for (int i = n; i < MIN_PAY; i++) begin
                exp_q.push_back(9'h000);
                c = crc_upd(c, 8'h00);
            end
            fcs = ~c;
            for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, fcs[8*k +: 8]});
        end
    endtask

    // Offer n bytes; optional one-cycle starvation after under_at accepts, or stop after stop_at.
    task automatic send(input int off, input int n, input int under_at, input int stop_at,
                        input bit hold, output int acc_cnt);
        int  i;
        int  budget;
        bit  acc;
        i = 0;
        budget = 0;
        acc_cnt = 0;
        while (i < n) begin
            bus.validIn = 1'b1;
            bus.dataIn  = pay[off+i];
            bus.lastIn  = (i == n - 1);
            @(negedge clk);
            acc = bus.readyOut;
            @(posedge clk);
            #1;
            budget++;
            if (budget > 3000) begin
                chk("send_timeout", 64'(budget), 64'd0);
                break;
            end
            if (acc) begin
                i++;
                acc_cnt++;
                if (i == under_at) begin
                    bus.validIn = 1'b0;
                    bus.lastIn  = 1'b0;
                    @(posedge clk);
                    #1;
                end
                if (i == stop_at) break;
            end
        end
        if (!hold) begin
            bus.validIn = 1'b0;
            bus.lastIn  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        @(negedge clk);
        while (bus.busyOut && c < 500) begin
            @(negedge clk);
            c++;
        end
        if (c >= 500) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    // Per-cycle compare of GMII outputs against the expected byte queue.
    always @(negedge clk) begin
        if (started) begin
            if (bus.readyOut) rdy_cnt++;
            if (!rstB) frame_bad = 1;
            if (bus.txEnOut) begin
                if (!prev_en) begin
                    last_gap  = lo_run;
                    run       = 0;
                    frame_bad = !rstB;
                    cap.delete();
                end
                en_cnt++;
                run++;
                cap.push_back(bus.txDataOut);
                if (bus.txErrOut) frame_bad = 1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_tx_byte", {55'd0, bus.txErrOut, bus.txDataOut}, 64'h1FF);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("tx_byte", {55'd0, bus.txErrOut, bus.txDataOut}, {55'd0, e});
                end
            end else begin
                chk("txerr_without_txen", {63'd0, bus.txErrOut}, 64'd0);
                if (prev_en) begin
                    last_len = run;
                    lo_run   = 0;
                    if (!frame_bad) begin
                        logic [31:0] r;
                        r = 32'hFFFFFFFF;
                        for (int i = 8; i < cap.size(); i++) r = crc_upd(r, cap[i]);
                        last_res = r;
                        chk("fcs_residue", {32'd0, r}, {32'd0, RESIDUE});
                    end
                    $display("frame: %0d txEn cycles, aborted=%0d, frameCount=%0d",
                             run, frame_bad, bus.frameCountOut);
                end
                lo_run++;
            end
            prev_en = bus.txEnOut;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int rdy0;
        int en0;
        logic [31:0] c;

        bus.dataIn  = 8'h00;
        bus.validIn = 1'b0;
        bus.lastIn  = 1'b0;
        rstB        = 1'b0;

        // Pin the bench CRC model to the well-known check value
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) c = crc_upd(c, 8'(8'h31 + i));
        chk("crc_check_value", {32'd0, ~c}, 64'hCBF43926);

        // Reset state
        repeat (10) @(posedge clk);
        #1 rstB = 1'b1;
        @(negedge clk);
        started = 1;
        chk("rst_txData", {56'd0, bus.txDataOut}, 64'h00);
        chk("rst_txEn", {63'd0, bus.txEnOut}, 64'd0);
        chk("rst_txErr", {63'd0, bus.txErrOut}, 64'd0);
        chk("rst_ready", {63'd0, bus.readyOut}, 64'd0);
        chk("rst_busy", {63'd0, bus.busyOut}, 64'd0);
        chk("rst_frameCount", {48'd0, bus.frameCountOut}, 64'd0);
        en0 = en_cnt;
        repeat (100) @(negedge clk);
        chk("idle_txEn_cycles", 64'(en_cnt - en0), 64'd0);
        $display("txn reset/idle done");

        // 64-byte payload 0x00..0x3F
        for (int i = 0; i < 64; i++) pay[i] = 8'(i);
        push_exp(0, 64, 0);
        send(0, 64, 0, 0, 0, acc);
        wait_idle();
        chk("f64_len", 64'(last_len), 64'd76);
        chk("f64_residue", {32'd0, last_res}, 64'hDEBB20E3);
        chk("f64_frameCount", {48'd0, bus.frameCountOut}, 64'd1);
        $display("txn 64-byte frame accepted=%0d", acc);

        // 1-byte payload 0xAB
        pay[0] = 8'hAB;
        push_exp(0, 1, 0);
        rdy0 = rdy_cnt;
        send(0, 1, 0, 0, 0, acc);
        wait_idle();
        chk("f1_len", 64'(last_len), 64'd72);
        chk("f1_ready_cycles", 64'(rdy_cnt - rdy0), 64'd1);
        chk("f1_frameCount", {48'd0, bus.frameCountOut}, 64'd2);
        $display("txn 1-byte frame accepted=%0d", acc);

        // Underrun after 10 of 100 bytes
        for (int i = 0; i < 100; i++) pay[i] = 8'(i * 3 + 7);
        push_exp(0, 100, 10);
        rdy0 = rdy_cnt;
        send(0, 100, 10, 0, 0, acc);
        wait_idle();
        chk("ur_accepted", 64'(acc), 64'd100);
        chk("ur_len", 64'(last_len), 64'd19);
        chk("ur_ready_cycles", 64'(rdy_cnt - rdy0), 64'd101);
        chk("ur_frameCount", {48'd0, bus.frameCountOut}, 64'd2);
        $display("txn underrun frame accepted=%0d", acc);

        // Two back-to-back 60-byte frames, validIn held high
        for (int i = 0; i < 60; i++) pay[i] = 8'hF0 ^ 8'(i);
        for (int i = 0; i < 60; i++) pay[100+i] = 8'(i * 5 + 1);
        push_exp(0, 60, 0);
        push_exp(100, 60, 0);
        rdy0 = rdy_cnt;
        send(0, 60, 0, 0, 1, acc);
        send(100, 60, 0, 0, 0, acc);
        wait_idle();
        chk("b2b_gap", 64'(last_gap), 64'd13);
        chk("b2b_len", 64'(last_len), 64'd72);
        chk("b2b_ready_cycles", 64'(rdy_cnt - rdy0), 64'd120);
        chk("b2b_frameCount", {48'd0, bus.frameCountOut}, 64'd4);
        $display("txn back-to-back frames done");

        // Reset pulsed after 30 payload bytes
        for (int i = 0; i < 61; i++) pay[i] = 8'(8'hC3 - i);
        push_exp(0, 61, 0);
        send(0, 61, 0, 30, 0, acc);
        rstB = 1'b0;
        @(posedge clk);
        #1;
        rstB = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid_txEn", {63'd0, bus.txEnOut}, 64'd0);
        chk("rst_mid_txErr", {63'd0, bus.txErrOut}, 64'd0);
        chk("rst_mid_frameCount", {48'd0, bus.frameCountOut}, 64'd0);
        $display("txn mid-frame reset after %0d bytes", acc);

        // Fresh frame after reset
        push_exp(0, 61, 0);
        send(0, 61, 0, 0, 0, acc);
        wait_idle();
        chk("fresh_len", 64'(last_len), 64'd73);
        chk("fresh_residue", {32'd0, last_res}, 64'hDEBB20E3);
        chk("fresh_frameCount", {48'd0, bus.frameCountOut}, 64'd1);
        $display("txn fresh frame accepted=%0d", acc);

        repeat (5) @(negedge clk);
        chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
